// File: rtl/silife_grid_port.sv
// Serial load/readback port for one segment of a SiLife cell grid.
// Decodes a bit-serial protocol into row selects and one-hot cell set/clear strobes.
module silife_grid_port #(
    parameter int  WIDTH         = 32,
    parameter int  HEIGHT        = 32,
    parameter int  SEG_BITS      = 15,
    parameter int  ROW_ADDR_BITS = 16,
    localparam int ROW_BITS      = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load_cs,
    input  logic                i_load_clk,
    input  logic                i_load_data,
    output logic                o_load_data,
    input  logic [WIDTH-1:0]    i_row_cells,
    output logic                o_selected,
    output logic [ROW_BITS-1:0] o_row_select,
    output logic [WIDTH-1:0]    o_set_cells,
    output logic [WIDTH-1:0]    o_clear_cells
);

    localparam int COL_BITS = $clog2(WIDTH);
    localparam int MAX_BITS = (SEG_BITS > ROW_ADDR_BITS) ? SEG_BITS : ROW_ADDR_BITS;
    localparam int CNT_BITS = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_CONFIG,
        S_SEG_ADDR,
        S_ROW_ADDR,
        S_WRITE_DATA,
        S_READ_DATA,
        S_IGNORE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_load_clk_q;
    logic                r_armed;
    logic                r_op_hi;
    logic                r_is_read;
    logic [SEG_BITS-1:0] r_local_addr;
    logic [SEG_BITS-1:0] r_seg;
    logic [ROW_BITS-1:0] r_row_addr;
    logic [CNT_BITS-1:0] r_bit_cnt;
    logic [COL_BITS-1:0] r_cell_idx;
    logic [ROW_BITS-1:0] r_row_select;
    logic [WIDTH-1:0]    r_set_cells;
    logic [WIDTH-1:0]    r_clear_cells;

    logic                w_edge;
    logic                w_match;
    logic                w_seg_last;
    logic                w_row_last;
    logic                w_row_wrap;
    logic [WIDTH-1:0]    w_cell_onehot;
    logic [SEG_BITS-1:0] w_seg_next;
    logic [ROW_BITS-1:0] w_row_next;

    assign w_edge        = i_load_clk & ~r_load_clk_q;
    assign w_match       = (r_seg == r_local_addr);
    assign w_seg_last    = (r_bit_cnt == CNT_BITS'(SEG_BITS - 1));
    assign w_row_last    = (r_bit_cnt == CNT_BITS'(ROW_ADDR_BITS - 1));
    assign w_row_wrap    = (r_cell_idx == COL_BITS'(WIDTH - 1));
    assign w_cell_onehot = WIDTH'(1) << r_cell_idx;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_seg_next = r_seg;
        for (int b = 0; b < SEG_BITS; b++) begin
            if (r_bit_cnt == CNT_BITS'(b)) w_seg_next[b] = i_load_data;
        end
    end

    // Row address bits at or above ROW_BITS are shifted past and dropped.
    always_comb begin
        w_row_next = r_row_addr;
        for (int b = 0; b < ROW_BITS; b++) begin
            if (r_bit_cnt == CNT_BITS'(b)) w_row_next[b] = i_load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (i_load_cs) begin
            w_next_state = S_IDLE;
        end else if (w_edge) begin
            case (r_state)
                S_IDLE:     if (r_armed) w_next_state = S_OPCODE;
                S_OPCODE: begin
                    case ({r_op_hi, i_load_data})
                        2'b00, 2'b01: w_next_state = S_SEG_ADDR;
                        2'b10:        w_next_state = S_CONFIG;
                        default:      w_next_state = S_IGNORE;
                    endcase
                end
                S_CONFIG:   if (!i_load_data) w_next_state = S_IGNORE;
                S_SEG_ADDR: if (w_seg_last) w_next_state = S_ROW_ADDR;
                S_ROW_ADDR: if (w_row_last) w_next_state = r_is_read ? S_READ_DATA : S_WRITE_DATA;
                default:    w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        o_selected  = 1'b0;
        o_load_data = 1'b1;
        case (r_state)
            S_WRITE_DATA: o_selected = w_match;
            S_READ_DATA: begin
                o_selected = w_match;
                if (w_match) o_load_data = i_row_cells[r_cell_idx];
            end
            default: ;
        endcase
    end

    // A transfer may only start after chip select has been seen high since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_clk_q  <= 1'b0;
            r_armed       <= 1'b0;
            r_op_hi       <= 1'b0;
            r_is_read     <= 1'b0;
            r_local_addr  <= '0;
            r_seg         <= '0;
            r_row_addr    <= '0;
            r_bit_cnt     <= '0;
            r_cell_idx    <= '0;
            r_row_select  <= '0;
            r_set_cells   <= '0;
            r_clear_cells <= '0;
        end else begin
            r_load_clk_q  <= i_load_clk;
            r_set_cells   <= '0;
            r_clear_cells <= '0;
            if (i_load_cs) begin
                r_armed   <= 1'b1;
                r_bit_cnt <= '0;
            end else if (w_edge) begin
                case (r_state)
                    S_IDLE: if (r_armed) r_op_hi <= i_load_data;
                    S_OPCODE: begin
                        r_is_read <= i_load_data;
                        r_bit_cnt <= '0;
                        if (r_op_hi && !i_load_data) r_local_addr <= '0;
                    end
                    S_CONFIG: if (i_load_data) r_local_addr <= r_local_addr + 1'b1;
                    S_SEG_ADDR: begin
                        r_seg     <= w_seg_next;
                        r_bit_cnt <= w_seg_last ? '0 : r_bit_cnt + 1'b1;
                    end
                    S_ROW_ADDR: begin
                        r_row_addr <= w_row_next;
                        if (w_row_last) begin
                            r_bit_cnt    <= '0;
                            r_cell_idx   <= '0;
                            r_row_select <= w_row_next;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_WRITE_DATA, S_READ_DATA: begin
                        if ((r_state == S_WRITE_DATA) && w_match) begin
                            if (i_load_data) r_set_cells   <= w_cell_onehot;
                            else             r_clear_cells <= w_cell_onehot;
                        end
                        if (w_row_wrap) begin
                            r_cell_idx   <= '0;
                            r_row_select <= r_row_select + 1'b1;
                        end else begin
                            r_cell_idx <= r_cell_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_row_select  = r_row_select;
    assign o_set_cells   = r_set_cells;
    assign o_clear_cells = r_clear_cells;

endmodule

// File: tb/tb_silife_grid_port.sv
// Directed bench for silife_grid_port: table-driven transfers plus hand-written
// config, abort, reset-abort, wrap and ignore sequences.
module tb_silife_grid_port;

    localparam int WIDTH         = 8;
    localparam int HEIGHT        = 8;
    localparam int SEG_BITS      = 4;
    localparam int ROW_ADDR_BITS = 5;
    localparam int ROW_BITS      = 3;

    typedef struct {
        logic [1:0]          op;
        logic [15:0]         seg;
        logic [15:0]         row;
        int                  nbits;
        logic [15:0]         data;
        logic [WIDTH-1:0]    exp_set;
        logic [WIDTH-1:0]    exp_clr;
        logic [ROW_BITS-1:0] exp_row;
        logic [15:0]         exp_rd;
        logic                exp_sel;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_load_cs;
    logic                i_load_clk;
    logic                i_load_data;
    logic                o_load_data;
    logic [WIDTH-1:0]    i_row_cells;
    logic                o_selected;
    logic [ROW_BITS-1:0] o_row_select;
    logic [WIDTH-1:0]    o_set_cells;
    logic [WIDTH-1:0]    o_clear_cells;

    logic [WIDTH-1:0] grid [HEIGHT];
    vec_t             vecs [10];

    int               n_pass  = 0;
    int               n_total = 0;
    logic             bit_rd;
    logic             bit_sel;
    logic [WIDTH-1:0] bit_set;
    logic [WIDTH-1:0] bit_clr;
    logic [WIDTH-1:0] acc_set;
    logic [WIDTH-1:0] acc_clr;
    logic             shape_bad;
    logic             rd_all;

    always #5 clk = ~clk;

    assign i_row_cells = grid[o_row_select];

    silife_grid_port #(
        .WIDTH         (WIDTH),
        .HEIGHT        (HEIGHT),
        .SEG_BITS      (SEG_BITS),
        .ROW_ADDR_BITS (ROW_ADDR_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_load_cs     (i_load_cs),
        .i_load_clk    (i_load_clk),
        .i_load_data   (i_load_data),
        .o_load_data   (o_load_data),
        .i_row_cells   (i_row_cells),
        .o_selected    (o_selected),
        .o_row_select  (o_row_select),
        .o_set_cells   (o_set_cells),
        .o_clear_cells (o_clear_cells)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One serial bit: readback sampled before the rising edge, strobes one and two cycles later.
    task automatic ser_bit(input logic d);
        @(negedge clk);
        bit_rd      = o_load_data;
        bit_sel     = o_selected;
        i_load_data = d;
        i_load_clk  = 1'b1;
        @(negedge clk);
        bit_set = o_set_cells;
        bit_clr = o_clear_cells;
        if (($countones(bit_set | bit_clr) > 1) || ((bit_set & bit_clr) != '0)) shape_bad = 1'b1;
        acc_set    = acc_set | bit_set;
        acc_clr    = acc_clr | bit_clr;
        i_load_clk = 1'b0;
        @(negedge clk);
        if ((o_set_cells | o_clear_cells) != '0) shape_bad = 1'b1;
    endtask

    task automatic send_field(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) ser_bit(v[i]);
    endtask

    task automatic cs_cycle();
        @(negedge clk);
        i_load_cs  = 1'b1;
        i_load_clk = 1'b0;
        repeat (2) @(negedge clk);
        i_load_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_acc();
        acc_set   = '0;
        acc_clr   = '0;
        shape_bad = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [15:0] rd_seq;
        logic        sel_seen;
        cs_cycle();
        clear_acc();
        ser_bit(v.op[1]);
        ser_bit(v.op[0]);
        send_field(v.seg, SEG_BITS);
        send_field(v.row, ROW_ADDR_BITS);
        rd_seq   = '0;
        sel_seen = 1'b0;
        for (int i = 0; i < v.nbits; i++) begin
            ser_bit(v.data[i]);
            rd_seq[i] = bit_rd;
            if (i == 0) sel_seen = bit_sel;
        end
        check($sformatf("v%0d set", idx), 32'(acc_set), 32'(v.exp_set));
        check($sformatf("v%0d clear", idx), 32'(acc_clr), 32'(v.exp_clr));
        check($sformatf("v%0d row", idx), 32'(o_row_select), 32'(v.exp_row));
        check($sformatf("v%0d readback", idx), 32'(rd_seq), 32'(v.exp_rd));
        check($sformatf("v%0d selected", idx), 32'(sel_seen), 32'(v.exp_sel));
        check($sformatf("v%0d strobe_shape", idx), 32'(shape_bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        i_load_cs   = 1'b1;
        i_load_clk  = 1'b0;
        i_load_data = 1'b0;
        for (int r = 0; r < HEIGHT; r++) grid[r] = '0;
        grid[5] = 8'hA5;
        clear_acc();

        //          op     seg     row       n  data      set    clr    row   rd        sel
        vecs[0] = '{2'b00, 16'd0, 16'd3,     3, 16'h0005, 8'h05, 8'h02, 3'd3, 16'h0007, 1'b1};
        vecs[1] = '{2'b01, 16'd0, 16'd5,     8, 16'h0000, 8'h00, 8'h00, 3'd6, 16'h00A5, 1'b1};
        vecs[2] = '{2'b00, 16'd1, 16'd2,     4, 16'h000F, 8'h00, 8'h00, 3'd2, 16'h000F, 1'b0};
        vecs[3] = '{2'b01, 16'd2, 16'd5,     8, 16'h0000, 8'h00, 8'h00, 3'd6, 16'h00FF, 1'b0};
        vecs[4] = '{2'b00, 16'd0, 16'b10110, 4, 16'h000C, 8'h0C, 8'h03, 3'd6, 16'h000F, 1'b1};
        vecs[5] = '{2'b00, 16'd0, 16'd7,     9, 16'h0100, 8'h01, 8'hFF, 3'd0, 16'h01FF, 1'b1};
        vecs[6] = '{2'b00, 16'd0, 16'd4,     2, 16'h0002, 8'h02, 8'h01, 3'd4, 16'h0003, 1'b1};
        vecs[7] = '{2'b00, 16'd3, 16'd1,     8, 16'h003C, 8'h3C, 8'hC3, 3'd2, 16'h00FF, 1'b1};
        vecs[8] = '{2'b00, 16'd0, 16'd4,     3, 16'h0007, 8'h00, 8'h00, 3'd4, 16'h0007, 1'b0};
        vecs[9] = '{2'b01, 16'd3, 16'd5,     8, 16'h0000, 8'h00, 8'h00, 3'd6, 16'h00A5, 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset set", 32'(o_set_cells), 32'd0);
        check("reset clear", 32'(o_clear_cells), 32'd0);
        check("reset row", 32'(o_row_select), 32'd0);
        check("reset load_data", 32'(o_load_data), 32'd1);
        check("reset selected", 32'(o_selected), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
        // Vector 5 ends on the wrap into row 0: its last bit must hit cell 0.
        check("wrap last set", 32'(bit_set), 32'h01);
        check("wrap last clear", 32'(bit_clr), 32'h00);

        // Chip select rises part-way through the row address.
        cs_cycle();
        clear_acc();
        ser_bit(1'b0);
        ser_bit(1'b0);
        send_field(16'd0, SEG_BITS);
        ser_bit(1'b1);
        ser_bit(1'b1);
        check("abort stray strobes", 32'(acc_set | acc_clr), 32'd0);
        run_vec(6, vecs[6]);

        // Reset in the middle of a write, with chip select held low afterwards.
        cs_cycle();
        ser_bit(1'b0);
        ser_bit(1'b0);
        send_field(16'd0, SEG_BITS);
        send_field(16'd2, ROW_ADDR_BITS);
        ser_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_abort strobes", 32'(o_set_cells | o_clear_cells), 32'd0);
        check("rst_abort row", 32'(o_row_select), 32'd0);
        check("rst_abort load_data", 32'(o_load_data), 32'd1);
        check("rst_abort selected", 32'(o_selected), 32'd0);
        clear_acc();
        for (int i = 0; i < 14; i++) ser_bit(i >= 12);
        check("rst_abort no restart", 32'(acc_set | acc_clr), 32'd0);
        check("rst_abort idle selected", 32'(o_selected), 32'd0);

        // Opcode 11 followed by 40 edges.
        cs_cycle();
        clear_acc();
        ser_bit(1'b1);
        ser_bit(1'b1);
        rd_all = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ser_bit(1'(i % 2));
            rd_all = rd_all & bit_rd;
        end
        check("ignore strobes", 32'(acc_set | acc_clr), 32'd0);
        check("ignore load_data", 32'(rd_all), 32'd1);
        check("ignore selected", 32'(o_selected), 32'd0);

        // Config: opcode 10, three ones, then a zero -> local address 3.
        cs_cycle();
        clear_acc();
        ser_bit(1'b1);
        ser_bit(1'b0);
        for (int i = 0; i < 3; i++) ser_bit(1'b1);
        ser_bit(1'b0);
        check("config strobes", 32'(acc_set | acc_clr), 32'd0);
        for (int i = 7; i < 10; i++) run_vec(i, vecs[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/silife_grid_port.md
SILIFE_GRID_PORT -- requirements
Module: silife_grid_port

Interface
REQ-001 SHALL have parameter WIDTH, default 32: cells per row; power of two, 8..64.
REQ-002 SHALL have parameter HEIGHT, default 32: rows in grid; power of two, 2..256.
REQ-003 SHALL have parameter SEG_BITS, default 15: segment address width, 1..16.
REQ-004 SHALL have parameter ROW_ADDR_BITS, default 16: serial row address width, at least ROW_BITS.
REQ-005 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port i_load_cs  input  1: serial chip select, active low; already synchronised to clk.
REQ-008 SHALL have port i_load_clk  input  1: serial clock; already synchronised to clk.
REQ-009 SHALL have port i_load_data  input  1: serial data in; already synchronised to clk.
REQ-010 SHALL have port o_load_data  output  1: serial readback data, wired-AND friendly (idle 1).
REQ-011 SHALL have port i_row_cells  input  WIDTH: current contents of row o_row_select, combinational from grid.
REQ-012 SHALL have port o_selected  output  1: high while this segment is addressed in any data phase.
REQ-013 SHALL have port o_row_select  output  ROW_BITS (= clog2 HEIGHT): grid row addressed.
REQ-014 SHALL have ports o_set_cells and o_clear_cells  output  WIDTH each: one-cycle cell write strobes.

Function
REQ-015 SHALL detect a serial edge when i_load_clk is 1 and was 0 on the previous clk cycle; all protocol actions occur only on such edges.
REQ-016 SHALL implement states IDLE, OPCODE, CONFIG, SEG_ADDR, ROW_ADDR, WRITE_DATA, READ_DATA, IGNORE.
REQ-017 SHALL force state IDLE, clear bit counter, clear strobes whenever i_load_cs is 1, overriding any edge in that cycle; local address is retained.
REQ-018 SHALL move IDLE->OPCODE on the first edge with i_load_cs 0, capturing opcode bit 1 (MSB-first); the second edge captures bit 0 and dispatches.
REQ-019 SHALL decode opcodes: 00 -> SEG_ADDR (write), 01 -> SEG_ADDR (read), 10 -> CONFIG, 11 -> IGNORE until i_load_cs rises.
REQ-020 In CONFIG, SHALL clear local address on entry and increment it (SEG_BITS, wrapping) per edge with data 1; an edge with data 0 moves to IGNORE.
REQ-021 SHALL shift SEG_BITS bits LSB-first into the selected segment, then ROW_ADDR_BITS bits LSB-first into the row address, then enter WRITE_DATA or READ_DATA per opcode.
REQ-022 SHALL drive o_row_select from row address bits [ROW_BITS-1:0], updated on data-phase entry and on each row advance; unused upper address bits are ignored.
REQ-023 selected = (selected segment == local address); o_selected = selected and state in {WRITE_DATA, READ_DATA}.
REQ-024 In WRITE_DATA, when selected, each edge SHALL pulse o_set_cells[idx] (data 1) or o_clear_cells[idx] (data 0) for exactly one clk cycle, one cycle after the edge-detect cycle; idx = cell counter.
REQ-025 In READ_DATA, o_load_data SHALL equal i_row_cells[idx] when selected, else 1; each edge advances idx; outside READ_DATA o_load_data is 1.
REQ-026 After cell index WIDTH-1, SHALL wrap idx to 0 and increment the row address; row HEIGHT-1 wraps to row 0.
REQ-027 Not-selected segments SHALL track counters and rows identically but issue no strobes.
REQ-028 Strobe vectors SHALL have at most one bit set per cycle and SHALL never set and clear the same cell.

Reset
REQ-029 On reset: state IDLE, local address 0, selected segment 0, row address 0, counters 0, o_set_cells/o_clear_cells 0, o_row_select 0, o_load_data 1, o_selected 0.
REQ-030 Reset during any transfer SHALL abort it with no further strobes; a new transfer needs i_load_cs high then low.

Verification
REQ-031 Write: opcode 00, seg 0, row 3, data 1,0,1 -> set[0], clear[1], set[2] pulses, o_row_select=3.
REQ-032 Config then write: opcode 10 + three 1s + 0; CS cycle; write to seg 3 -> strobes; write to seg 0 -> none, o_selected 0.
REQ-033 Read: row 5 holds 0xA5 in bits 7:0, opcode 01 seg 0 row 5 -> o_load_data sequence 1,0,1,0,0,1,0,1.
REQ-034 Wrap: write starting row HEIGHT-1, WIDTH+1 bits -> last bit strobes cell 0 of row 0.
REQ-035 Abort: i_load_cs high mid-row-address, then new write -> address restarts from bit 0, no stray strobes.
REQ-036 Opcode 11 followed by 40 edges -> no strobes, o_load_data stays 1.
